axi_to_ready_valid_multi: RTL and testbench
===========================================

Name: axi_to_ready_valid_multi

Overview:
- AXI4-Lite slave that bridges single-beat register accesses onto N_CH independent ready/valid user channels.
- Parametrised successor of the single-channel AXI-to-ready/valid bridge.
- Adds word-address channel decode, DECERR for unmapped addresses, SLVERR propagation from the user side, and a programmable per-access user timeout.
- Read and write paths are independent and may be in flight concurrently.

Parameters:
- N_CH, 4: number of user channels (1..16).
- DATA_W, 32: AXI and user data width (32 or 64).
- ADDR_W, 6: AXI address width. Must satisfy 2^(ADDR_W-2) >= N_CH.
- TIMEOUT_CYC, 0: cycles to wait for a user handshake before aborting with SLVERR. 0 disables the timeout.

Ports:
- S00_AXI_aclk  in  1  clock.
- S00_AXI_areset  in  1  asynchronous, active-high reset.
- S00_AXI_awaddr  in  ADDR_W  write address.
- S00_AXI_awvalid  in  1 / S00_AXI_awready  out  1
- S00_AXI_wdata  in  DATA_W / S00_AXI_wvalid  in  1 / S00_AXI_wready  out  1
- S00_AXI_bresp  out  2 / S00_AXI_bvalid  out  1 / S00_AXI_bready  in  1
- S00_AXI_araddr  in  ADDR_W / S00_AXI_arvalid  in  1 / S00_AXI_arready  out  1
- S00_AXI_rdata  out  DATA_W / S00_AXI_rresp  out  2 / S00_AXI_rvalid  out  1 / S00_AXI_rready  in  1
- ch_wvalid_o  out  N_CH  one-hot write request.
- ch_wdata_o  out  DATA_W  write data, broadcast to all channels.
- ch_wready_i  in  N_CH
- ch_werror_i  in  N_CH  sampled on the write handshake.
- ch_rready_o  out  N_CH  one-hot read request.
- ch_rvalid_i  in  N_CH
- ch_rdata_i  in  N_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- ch_rerror_i  in  N_CH  sampled on the read handshake.

Behaviour:
- Reset:
  - Asynchronous; all FSMs go to IDLE and any pending transaction is dropped with no response.
  - Every output resets to 0 (awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, ch_wvalid_o, ch_rready_o, ch_wdata_o).
- Decode: idx = addr[ADDR_W-1:2]. If idx >= N_CH the access is unmapped; byte-offset bits [1:0] are ignored.
- Write FSM, states W_IDLE -> W_USER -> W_RESP -> W_IDLE:
  - W_IDLE: awready=1 until the address is latched and wready=1 until the data is latched. AW and W are accepted independently, in either order or in the same cycle.
  - Once both are latched: a mapped access goes to W_USER; an unmapped access goes directly to W_RESP with bresp=2'b11 (DECERR), and no ch_wvalid_o asserts.
  - W_USER: ch_wvalid_o[idx]=1 with ch_wdata_o held stable until ch_wready_i[idx]. On that handshake cycle, bresp = ch_werror_i[idx] ? 2'b10 : 2'b00.
  - W_RESP: bvalid=1 with bresp stable until bready; return to W_IDLE on the cycle after the handshake.
  - Minimum latency: AW+W handshake at edge k, ch_wvalid_o high after edge k, bvalid high after the user handshake edge.
- Read FSM, states R_IDLE -> R_USER -> R_RESP -> R_IDLE:
  - R_IDLE: arready=1.
  - After AR is accepted: a mapped access goes to R_USER; an unmapped access goes to R_RESP with rresp=2'b11 and rdata=0.
  - R_USER: ch_rready_o[idx]=1 until ch_rvalid_i[idx]. Capture ch_rdata_i slice idx into rdata. rresp = ch_rerror_i[idx] ? 2'b10 : 2'b00.
  - R_RESP: rvalid=1 with rdata/rresp stable until rready.
- Timeout (TIMEOUT_CYC>0):
  - Each USER state has its own counter, cleared on entry.
  - If the counter reaches TIMEOUT_CYC without a handshake, drop the ch_* request and go to RESP with SLVERR.
  - For reads, rdata=0 in this case.
  - A handshake in the same cycle as expiry wins over the timeout.
- At most one asserted bit in ch_wvalid_o and at most one in ch_rready_o at any time.
- Read and write to the same channel concurrently is legal; the two paths do not arbitrate.
- Inputs on non-selected channels are ignored.

Test Plan:
1. Write 0xDEADBEEF to addr 0x8 (ch2), W presented 3 cycles before AW -> ch_wvalid_o=4'b0100 with ch_wdata_o=0xDEADBEEF; ch_wready_i[2] pulses -> bvalid with bresp=00; bready clears bvalid next cycle.
2. Read addr 0x4 (ch1), ch_rvalid_i[1] after 5 cycles with data 0x12345678 and rerror=1 -> rvalid, rdata=0x12345678, rresp=10.
3. Write to addr 0x3C and read 0x30 with N_CH=4 -> no ch_* activity; bresp=11; rresp=11 with rdata=0.
4. TIMEOUT_CYC=8, write to ch0 with ch_wready_i held low -> ch_wvalid_o[0] drops after 8 cycles; bresp=10. Next write to ch0 completes normally.
5. Concurrent write to ch3 and read from ch0, AW/W/AR in the same cycle, with bready/rready stalled 4 cycles -> both complete with OKAY; bvalid/rvalid and their data stay stable while stalled.
6. Assert reset while in W_USER and R_RESP -> all outputs 0 immediately (asynchronous); after deassertion awready/wready/arready=1 and a fresh read succeeds.

Source files
------------

// File: rtl/axi_to_ready_valid_multi_if.sv
// Bus bundle for axi_to_ready_valid_multi.
// Covers the AXI4-Lite slave port and the N_CH user-side ready/valid channels.
interface axi_to_ready_valid_multi_if #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 6
);
  logic [ADDR_W-1:0]      S00_AXI_awaddr;
  logic                   S00_AXI_awvalid;
  logic                   S00_AXI_awready;
  logic [DATA_W-1:0]      S00_AXI_wdata;
  logic                   S00_AXI_wvalid;
  logic                   S00_AXI_wready;
  logic [1:0]             S00_AXI_bresp;
  logic                   S00_AXI_bvalid;
  logic                   S00_AXI_bready;
  logic [ADDR_W-1:0]      S00_AXI_araddr;
  logic                   S00_AXI_arvalid;
  logic                   S00_AXI_arready;
  logic [DATA_W-1:0]      S00_AXI_rdata;
  logic [1:0]             S00_AXI_rresp;
  logic                   S00_AXI_rvalid;
  logic                   S00_AXI_rready;
  logic [N_CH-1:0]        ch_wvalid_o;
  logic [DATA_W-1:0]      ch_wdata_o;
  logic [N_CH-1:0]        ch_wready_i;
  logic [N_CH-1:0]        ch_werror_i;
  logic [N_CH-1:0]        ch_rready_o;
  logic [N_CH-1:0]        ch_rvalid_i;
  logic [N_CH*DATA_W-1:0] ch_rdata_i;
  logic [N_CH-1:0]        ch_rerror_i;

  modport slave (
    input  S00_AXI_awaddr, S00_AXI_awvalid, S00_AXI_wdata, S00_AXI_wvalid, S00_AXI_bready,
    input  S00_AXI_araddr, S00_AXI_arvalid, S00_AXI_rready,
    output S00_AXI_awready, S00_AXI_wready, S00_AXI_bresp, S00_AXI_bvalid,
    output S00_AXI_arready, S00_AXI_rdata, S00_AXI_rresp, S00_AXI_rvalid,
    output ch_wvalid_o, ch_wdata_o, ch_rready_o,
    input  ch_wready_i, ch_werror_i, ch_rvalid_i, ch_rdata_i, ch_rerror_i
  );

  modport master (
    output S00_AXI_awaddr, S00_AXI_awvalid, S00_AXI_wdata, S00_AXI_wvalid, S00_AXI_bready,
    output S00_AXI_araddr, S00_AXI_arvalid, S00_AXI_rready,
    input  S00_AXI_awready, S00_AXI_wready, S00_AXI_bresp, S00_AXI_bvalid,
    input  S00_AXI_arready, S00_AXI_rdata, S00_AXI_rresp, S00_AXI_rvalid,
    input  ch_wvalid_o, ch_wdata_o, ch_rready_o,
    output ch_wready_i, ch_werror_i, ch_rvalid_i, ch_rdata_i, ch_rerror_i
  );
endinterface

// File: rtl/axi_to_ready_valid_multi.sv
// AXI4-Lite slave bridging single-beat accesses onto N_CH ready/valid channels,
// with word-address decode, DECERR/SLVERR responses and an optional user timeout.
module axi_to_ready_valid_multi #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input logic S00_AXI_aclk,
  input logic S00_AXI_areset,
  axi_to_ready_valid_multi_if.slave bus
);
  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {W_IDLE, W_USER, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_USER, R_RESP} r_state_t;

  // Word index to one-hot channel select; all-zero means unmapped.
  function automatic logic [N_CH-1:0] decode(input logic [IDX_W-1:0] idx);
    logic [N_CH-1:0] sel;
    sel = '0;
    for (int unsigned k = 0; k < N_CH; k++) sel[k] = (32'(idx) == k);
    return sel;
  endfunction

  logic [N_CH-1:0] aw_dec, ar_dec;
  logic            unused_addr_lsbs;
  assign aw_dec           = decode(bus.S00_AXI_awaddr[ADDR_W-1:2]);
  assign ar_dec           = decode(bus.S00_AXI_araddr[ADDR_W-1:2]);
  assign unused_addr_lsbs = ^{bus.S00_AXI_awaddr[1:0], bus.S00_AXI_araddr[1:0]};

  // Write path registers and their next values
  w_state_t          w_state, w_state_n;
  logic              aw_got, aw_got_n, w_got, w_got_n;
  logic [N_CH-1:0]   w_sel, w_sel_n;
  logic              awready_q, awready_n, wready_q, wready_n;
  logic              bvalid_q, bvalid_n;
  logic [1:0]        bresp_q, bresp_n;
  logic [N_CH-1:0]   ch_wvalid_q, ch_wvalid_n;
  logic [DATA_W-1:0] ch_wdata_q, ch_wdata_n;
  logic [CNT_W-1:0]  w_cnt, w_cnt_n;
  logic              w_expire;

  // Read path registers and their next values
  r_state_t          r_state, r_state_n;
  logic              arready_q, arready_n;
  logic              rvalid_q, rvalid_n;
  logic [1:0]        rresp_q, rresp_n;
  logic [DATA_W-1:0] rdata_q, rdata_n;
  logic [N_CH-1:0]   ch_rready_q, ch_rready_n;
  logic [CNT_W-1:0]  r_cnt, r_cnt_n;
  logic              r_expire;
  logic [DATA_W-1:0] rd_mux;

  assign w_expire = (TIMEOUT_CYC != 0) && (32'(w_cnt) == TIMEOUT_CYC - 1);
  assign r_expire = (TIMEOUT_CYC != 0) && (32'(r_cnt) == TIMEOUT_CYC - 1);

  always_ff @(posedge S00_AXI_aclk or posedge S00_AXI_areset) begin
    if (S00_AXI_areset) begin
      w_state     <= W_IDLE;
      aw_got      <= 1'b0;
      w_got       <= 1'b0;
      w_sel       <= '0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= 2'b00;
      ch_wvalid_q <= '0;
      ch_wdata_q  <= '0;
      w_cnt       <= '0;
      r_state     <= R_IDLE;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rresp_q     <= 2'b00;
      rdata_q     <= '0;
      ch_rready_q <= '0;
      r_cnt       <= '0;
    end else begin
      w_state     <= w_state_n;
      aw_got      <= aw_got_n;
      w_got       <= w_got_n;
      w_sel       <= w_sel_n;
      awready_q   <= awready_n;
      wready_q    <= wready_n;
      bvalid_q    <= bvalid_n;
      bresp_q     <= bresp_n;
      ch_wvalid_q <= ch_wvalid_n;
      ch_wdata_q  <= ch_wdata_n;
      w_cnt       <= w_cnt_n;
      r_state     <= r_state_n;
      arready_q   <= arready_n;
      rvalid_q    <= rvalid_n;
      rresp_q     <= rresp_n;
      rdata_q     <= rdata_n;
      ch_rready_q <= ch_rready_n;
      r_cnt       <= r_cnt_n;
    end
  end

  // Write FSM: collect AW and W in any order, then user handshake, then B.
  always_comb begin
    w_state_n   = w_state;
    aw_got_n    = aw_got;
    w_got_n     = w_got;
    w_sel_n     = w_sel;
    awready_n   = awready_q;
    wready_n    = wready_q;
    bvalid_n    = bvalid_q;
    bresp_n     = bresp_q;
    ch_wvalid_n = ch_wvalid_q;
    ch_wdata_n  = ch_wdata_q;
    w_cnt_n     = w_cnt;
    case (w_state)
      W_IDLE: begin
        if (bus.S00_AXI_awvalid && awready_q) begin
          aw_got_n = 1'b1;
          w_sel_n  = aw_dec;
        end
        if (bus.S00_AXI_wvalid && wready_q) begin
          w_got_n    = 1'b1;
          ch_wdata_n = bus.S00_AXI_wdata;
        end
        awready_n = !aw_got_n;
        wready_n  = !w_got_n;
        if (aw_got_n && w_got_n) begin
          aw_got_n  = 1'b0;
          w_got_n   = 1'b0;
          awready_n = 1'b0;
          wready_n  = 1'b0;
          w_cnt_n   = '0;
          if (|w_sel_n) begin
            ch_wvalid_n = w_sel_n;
            w_state_n   = W_USER;
          end else begin
            bvalid_n  = 1'b1;
            bresp_n   = 2'b11;
            w_state_n = W_RESP;
          end
        end
      end
      W_USER: begin
        // A handshake on the expiry cycle takes priority over the timeout.
        if (|(bus.ch_wready_i & ch_wvalid_q)) begin
          ch_wvalid_n = '0;
          bvalid_n    = 1'b1;
          bresp_n     = (|(bus.ch_werror_i & ch_wvalid_q)) ? 2'b10 : 2'b00;
          w_state_n   = W_RESP;
        end else if (w_expire) begin
          ch_wvalid_n = '0;
          bvalid_n    = 1'b1;
          bresp_n     = 2'b10;
          w_state_n   = W_RESP;
        end else begin
          w_cnt_n = w_cnt + CNT_W'(1);
        end
      end
      W_RESP: begin
        if (bus.S00_AXI_bready) begin
          bvalid_n  = 1'b0;
          awready_n = 1'b1;
          wready_n  = 1'b1;
          w_state_n = W_IDLE;
        end
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  // Selected channel's read data and error flag.
  logic rd_err;
  always_comb begin
    rd_mux = '0;
    rd_err = 1'b0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (ch_rready_q[k]) begin
        rd_mux = rd_mux | bus.ch_rdata_i[k*DATA_W +: DATA_W];
        rd_err = rd_err | bus.ch_rerror_i[k];
      end
    end
  end

  // Read FSM: accept AR, user handshake, then R.
  always_comb begin
    r_state_n   = r_state;
    arready_n   = arready_q;
    rvalid_n    = rvalid_q;
    rresp_n     = rresp_q;
    rdata_n     = rdata_q;
    ch_rready_n = ch_rready_q;
    r_cnt_n     = r_cnt;
    case (r_state)
      R_IDLE: begin
        arready_n = 1'b1;
        if (bus.S00_AXI_arvalid && arready_q) begin
          arready_n = 1'b0;
          r_cnt_n   = '0;
          if (|ar_dec) begin
            ch_rready_n = ar_dec;
            r_state_n   = R_USER;
          end else begin
            rvalid_n  = 1'b1;
            rresp_n   = 2'b11;
            rdata_n   = '0;
            r_state_n = R_RESP;
          end
        end
      end
      R_USER: begin
        if (|(bus.ch_rvalid_i & ch_rready_q)) begin
          ch_rready_n = '0;
          rvalid_n    = 1'b1;
          rdata_n     = rd_mux;
          rresp_n     = rd_err ? 2'b10 : 2'b00;
          r_state_n   = R_RESP;
        end else if (r_expire) begin
          ch_rready_n = '0;
          rvalid_n    = 1'b1;
          rdata_n     = '0;
          rresp_n     = 2'b10;
          r_state_n   = R_RESP;
        end else begin
          r_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      R_RESP: begin
        if (bus.S00_AXI_rready) begin
          rvalid_n  = 1'b0;
          arready_n = 1'b1;
          r_state_n = R_IDLE;
        end
      end
      default: r_state_n = R_IDLE;
    endcase
  end

  assign bus.S00_AXI_awready = awready_q;
  assign bus.S00_AXI_wready  = wready_q;
  assign bus.S00_AXI_bvalid  = bvalid_q;
  assign bus.S00_AXI_bresp   = bresp_q;
  assign bus.S00_AXI_arready = arready_q;
  assign bus.S00_AXI_rvalid  = rvalid_q;
  assign bus.S00_AXI_rresp   = rresp_q;
  assign bus.S00_AXI_rdata   = rdata_q;
  assign bus.ch_wvalid_o     = ch_wvalid_q;
  assign bus.ch_wdata_o      = ch_wdata_q;
  assign bus.ch_rready_o     = ch_rready_q;
endmodule

// File: tb/tb_axi_to_ready_valid_multi.sv
// Self-checking bench for axi_to_ready_valid_multi: directed scenarios plus
// randomized accesses checked against an address/latency reference model.
module tb_axi_to_ready_valid_multi;
  localparam int unsigned N_CH   = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned TO     = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  axi_to_ready_valid_multi_if #(.N_CH(N_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  axi_to_ready_valid_multi #(.N_CH(N_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TO)) dut (
    .S00_AXI_aclk   (clk),
    .S00_AXI_areset (rst),
    .bus            (bus)
  );

  // Reference model: word index selects a channel, indices >= N_CH are unmapped.
  function automatic logic [N_CH-1:0] exp_onehot(input logic [ADDR_W-1:0] a);
    int unsigned i;
    i = int'(a) / 4;
    return (i < N_CH) ? (N_CH'(1) << i) : '0;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [ADDR_W-1:0] a, input int dly, input logic err);
    if (exp_onehot(a) == '0) return 2'b11;
    if (dly >= int'(TO)) return 2'b10;
    return err ? 2'b10 : 2'b00;
  endfunction

  function automatic int exp_cycles(input logic [ADDR_W-1:0] a, input int dly);
    if (exp_onehot(a) == '0) return 0;
    return (dly >= int'(TO)) ? int'(TO) : dly + 1;
  endfunction

  function automatic logic [N_CH*DATA_W-1:0] rd_bus(input logic [N_CH-1:0] sel, input logic [DATA_W-1:0] d);
    logic [N_CH*DATA_W-1:0] v;
    for (int k = 0; k < int'(N_CH); k++) v[k*DATA_W +: DATA_W] = sel[k] ? d : DATA_W'($urandom);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one AXI write and plays the selected user channel (ready after dly request cycles).
  task automatic axi_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                           input int w_lead, input int dly, input logic err, input int stall,
                           output logic [1:0] resp, output logic [N_CH-1:0] wv_seen, output int wv_cyc,
                           output bit bad_data, output bit bad_hold, output bit multi,
                           output logic b_after, output bit hung);
    logic [N_CH-1:0] eb;
    bit aw_done, w_done, hs_aw, hs_w;
    int c, act;
    eb = exp_onehot(addr);
    resp = 2'b00; wv_seen = '0; wv_cyc = 0; bad_data = 0; bad_hold = 0; multi = 0; b_after = 1'b1; hung = 0;
    bus.S00_AXI_wdata = data; bus.S00_AXI_wvalid = 1'b1; bus.S00_AXI_awaddr = addr; bus.S00_AXI_awvalid = 1'b0;
    c = 0; aw_done = 0; w_done = 0;
    while (!(aw_done && w_done)) begin
      if (c > 60) begin
        hung = 1; bus.S00_AXI_awvalid = 1'b0; bus.S00_AXI_wvalid = 1'b0; return;
      end
      if (!aw_done && c >= w_lead) bus.S00_AXI_awvalid = 1'b1;
      hs_aw = bus.S00_AXI_awvalid && bus.S00_AXI_awready;
      hs_w  = bus.S00_AXI_wvalid && bus.S00_AXI_wready;
      step(); c++;
      if (hs_aw) begin aw_done = 1; bus.S00_AXI_awvalid = 1'b0; end
      if (hs_w)  begin w_done = 1;  bus.S00_AXI_wvalid = 1'b0; end
    end
    act = 0; c = 0;
    while (bus.S00_AXI_bvalid !== 1'b1) begin
      if (c > 60) begin hung = 1; bus.ch_wready_i = '0; return; end
      bus.ch_wready_i = N_CH'($urandom) & ~eb;
      bus.ch_werror_i = (N_CH'($urandom) & ~eb) | (err ? eb : '0);
      if (bus.ch_wvalid_o != '0) begin
        wv_seen |= bus.ch_wvalid_o; wv_cyc++;
        if ($countones(bus.ch_wvalid_o) > 1) multi = 1;
        if (bus.ch_wdata_o !== data) bad_data = 1;
        if (act == dly) bus.ch_wready_i = bus.ch_wready_i | eb;
        act++;
      end
      step(); c++;
    end
    bus.ch_wready_i = '0; bus.ch_werror_i = '0;
    resp = bus.S00_AXI_bresp;
    for (int s = 0; s < stall; s++) begin
      step();
      if (bus.S00_AXI_bvalid !== 1'b1 || bus.S00_AXI_bresp !== resp) bad_hold = 1;
    end
    bus.S00_AXI_bready = 1'b1; step(); bus.S00_AXI_bready = 1'b0;
    b_after = bus.S00_AXI_bvalid;
  endtask

  // Drives one AXI read and plays the selected user channel (valid after dly request cycles).
  task automatic axi_read(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                          input int dly, input logic err, input int stall,
                          output logic [1:0] resp, output logic [DATA_W-1:0] rdata,
                          output logic [N_CH-1:0] rr_seen, output int rr_cyc,
                          output bit bad_hold, output bit multi, output logic r_after, output bit hung);
    logic [N_CH-1:0] eb;
    bit hs;
    int c, act;
    eb = exp_onehot(addr);
    resp = 2'b00; rdata = '0; rr_seen = '0; rr_cyc = 0; bad_hold = 0; multi = 0; r_after = 1'b1; hung = 0;
    bus.S00_AXI_araddr = addr; bus.S00_AXI_arvalid = 1'b1;
    c = 0; hs = 0;
    while (!hs) begin
      if (c > 60) begin hung = 1; bus.S00_AXI_arvalid = 1'b0; return; end
      hs = bus.S00_AXI_arready;
      step(); c++;
    end
    bus.S00_AXI_arvalid = 1'b0;
    act = 0; c = 0;
    while (bus.S00_AXI_rvalid !== 1'b1) begin
      if (c > 60) begin hung = 1; bus.ch_rvalid_i = '0; return; end
      bus.ch_rvalid_i = N_CH'($urandom) & ~eb;
      bus.ch_rerror_i = (N_CH'($urandom) & ~eb) | (err ? eb : '0);
      bus.ch_rdata_i  = rd_bus(eb, data);
      if (bus.ch_rready_o != '0) begin
        rr_seen |= bus.ch_rready_o; rr_cyc++;
        if ($countones(bus.ch_rready_o) > 1) multi = 1;
        if (act == dly) bus.ch_rvalid_i = bus.ch_rvalid_i | eb;
        act++;
      end
      step(); c++;
    end
    bus.ch_rvalid_i = '0; bus.ch_rerror_i = '0;
    resp = bus.S00_AXI_rresp; rdata = bus.S00_AXI_rdata;
    for (int s = 0; s < stall; s++) begin
      bus.ch_rdata_i = rd_bus('0, '0);
      step();
      if (bus.S00_AXI_rvalid !== 1'b1 || bus.S00_AXI_rresp !== resp || bus.S00_AXI_rdata !== rdata) bad_hold = 1;
    end
    bus.S00_AXI_rready = 1'b1; step(); bus.S00_AXI_rready = 1'b0;
    r_after = bus.S00_AXI_rvalid;
  endtask

  task automatic test_reset();
    total++; if ({bus.S00_AXI_awready, bus.S00_AXI_wready, bus.S00_AXI_arready, bus.S00_AXI_bvalid, bus.S00_AXI_rvalid} !== 5'b0) begin bad++; $display("FAIL reset_flags: got %b want 00000", {bus.S00_AXI_awready, bus.S00_AXI_wready, bus.S00_AXI_arready, bus.S00_AXI_bvalid, bus.S00_AXI_rvalid}); end
    total++; if ({bus.ch_wvalid_o, bus.ch_rready_o, bus.ch_wdata_o, bus.S00_AXI_rdata, bus.S00_AXI_bresp, bus.S00_AXI_rresp} !== '0) begin bad++; $display("FAIL reset_data: got nonzero user/data outputs"); end
    #12 rst = 1'b0;
    step(); step();
    total++; if ({bus.S00_AXI_awready, bus.S00_AXI_wready, bus.S00_AXI_arready} !== 3'b111) begin bad++; $display("FAIL reset_ready: got %b want 111", {bus.S00_AXI_awready, bus.S00_AXI_wready, bus.S00_AXI_arready}); end
  endtask

  task automatic test_write_w_first();
    logic [1:0] resp; logic [N_CH-1:0] seen; int cyc; bit bd, bh, mu, hg; logic ba;
    axi_write(6'h08, 32'hDEADBEEF, 3, 2, 1'b0, 0, resp, seen, cyc, bd, bh, mu, ba, hg);
    total++; if (hg) begin bad++; $display("FAIL wr_first_hang: got timeout want completion"); end
    total++; if (seen !== 4'b0100) begin bad++; $display("FAIL wr_first_chan: got %b want 0100", seen); end
    total++; if (bd) begin bad++; $display("FAIL wr_first_wdata: got unstable/wrong wdata want DEADBEEF"); end
    total++; if (cyc != 3) begin bad++; $display("FAIL wr_first_cycles: got %0d want 3", cyc); end
    total++; if (resp !== 2'b00) begin bad++; $display("FAIL wr_first_bresp: got %b want 00", resp); end
    total++; if (ba !== 1'b0) begin bad++; $display("FAIL wr_first_bclear: got bvalid=%b want 0", ba); end
  endtask

  task automatic test_read_error();
    logic [1:0] resp; logic [DATA_W-1:0] rd; logic [N_CH-1:0] seen; int cyc; bit bh, mu, hg; logic ra;
    axi_read(6'h04, 32'h12345678, 5, 1'b1, 0, resp, rd, seen, cyc, bh, mu, ra, hg);
    total++; if (hg) begin bad++; $display("FAIL rd_err_hang: got timeout want completion"); end
    total++; if (seen !== 4'b0010) begin bad++; $display("FAIL rd_err_chan: got %b want 0010", seen); end
    total++; if (cyc != 6) begin bad++; $display("FAIL rd_err_cycles: got %0d want 6", cyc); end
    total++; if (rd !== 32'h12345678) begin bad++; $display("FAIL rd_err_data: got %h want 12345678", rd); end
    total++; if (resp !== 2'b10) begin bad++; $display("FAIL rd_err_rresp: got %b want 10", resp); end
    total++; if (ra !== 1'b0) begin bad++; $display("FAIL rd_err_rclear: got rvalid=%b want 0", ra); end
  endtask

  task automatic test_decerr();
    logic [1:0] resp; logic [DATA_W-1:0] rd; logic [N_CH-1:0] seen; int cyc; bit bd, bh, mu, hg; logic ba;
    axi_write(6'h3C, 32'hCAFEF00D, 0, 0, 1'b0, 1, resp, seen, cyc, bd, bh, mu, ba, hg);
    total++; if (hg || seen !== '0) begin bad++; $display("FAIL decerr_wr_chan: got %b hang=%0d want 0000", seen, hg); end
    total++; if (resp !== 2'b11) begin bad++; $display("FAIL decerr_bresp: got %b want 11", resp); end
    axi_read(6'h30, 32'h55AA55AA, 0, 1'b0, 1, resp, rd, seen, cyc, bh, mu, ba, hg);
    total++; if (hg || seen !== '0) begin bad++; $display("FAIL decerr_rd_chan: got %b hang=%0d want 0000", seen, hg); end
    total++; if (resp !== 2'b11 || rd !== '0) begin bad++; $display("FAIL decerr_rresp: got %b/%h want 11/0", resp, rd); end
  endtask

  task automatic test_timeout();
    logic [1:0] resp; logic [DATA_W-1:0] rd; logic [N_CH-1:0] seen; int cyc; bit bd, bh, mu, hg; logic ba;
    axi_write(6'h00, 32'h0BADF00D, 0, 1000, 1'b0, 0, resp, seen, cyc, bd, bh, mu, ba, hg);
    total++; if (hg || cyc != int'(TO)) begin bad++; $display("FAIL to_wr_cycles: got %0d hang=%0d want %0d", cyc, hg, TO); end
    total++; if (resp !== 2'b10) begin bad++; $display("FAIL to_wr_bresp: got %b want 10", resp); end
    axi_write(6'h00, 32'h600DF00D, 0, 1, 1'b0, 0, resp, seen, cyc, bd, bh, mu, ba, hg);
    total++; if (hg || resp !== 2'b00 || cyc != 2) begin bad++; $display("FAIL to_wr_next: got %b/%0d want 00/2", resp, cyc); end
    axi_write(6'h04, 32'h1, 0, int'(TO) - 1, 1'b0, 0, resp, seen, cyc, bd, bh, mu, ba, hg);
    total++; if (resp !== 2'b00 || cyc != int'(TO)) begin bad++; $display("FAIL to_wr_edge: got %b/%0d want 00/%0d", resp, cyc, TO); end
    axi_read(6'h08, 32'hFFFFFFFF, 1000, 1'b0, 0, resp, rd, seen, cyc, bh, mu, ba, hg);
    total++; if (hg || resp !== 2'b10 || rd !== '0 || cyc != int'(TO)) begin bad++; $display("FAIL to_rd: got %b/%h/%0d want 10/0/%0d", resp, rd, cyc, TO); end
  endtask

  task automatic test_concurrent();
    logic [1:0] wresp, rresp; logic [DATA_W-1:0] rd; logic [N_CH-1:0] wseen, rseen;
    int wc, rc; bit bd, wbh, rbh, wmu, rmu, whg, rhg; logic ba, ra;
    fork
      axi_write(6'h0C, 32'hA5A5_0003, 0, 1, 1'b0, 4, wresp, wseen, wc, bd, wbh, wmu, ba, whg);
      axi_read(6'h00, 32'h3C3C_0000, 2, 1'b0, 4, rresp, rd, rseen, rc, rbh, rmu, ra, rhg);
    join
    total++; if (whg || rhg) begin bad++; $display("FAIL conc_hang: got wr=%0d rd=%0d want 0/0", whg, rhg); end
    total++; if (wseen !== 4'b1000 || rseen !== 4'b0001) begin bad++; $display("FAIL conc_chan: got %b/%b want 1000/0001", wseen, rseen); end
    total++; if (wresp !== 2'b00 || rresp !== 2'b00 || rd !== 32'h3C3C_0000) begin bad++; $display("FAIL conc_resp: got %b/%b/%h want 00/00/3c3c0000", wresp, rresp, rd); end
    total++; if (wbh || rbh || bd) begin bad++; $display("FAIL conc_hold: got bhold=%0d rhold=%0d wdata=%0d want 0", wbh, rbh, bd); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp; logic [DATA_W-1:0] rd; logic [N_CH-1:0] seen; int cyc; bit bh, mu, hg; logic ra;
    bus.S00_AXI_awaddr = 6'h04; bus.S00_AXI_awvalid = 1'b1; bus.S00_AXI_wdata = 32'h77; bus.S00_AXI_wvalid = 1'b1;
    bus.S00_AXI_araddr = 6'h00; bus.S00_AXI_arvalid = 1'b1; bus.ch_rvalid_i = 4'b0001; bus.ch_rdata_i = '0;
    step();
    bus.S00_AXI_awvalid = 1'b0; bus.S00_AXI_wvalid = 1'b0; bus.S00_AXI_arvalid = 1'b0;
    step();
    bus.ch_rvalid_i = '0;
    total++; if (bus.ch_wvalid_o !== 4'b0010 || bus.S00_AXI_rvalid !== 1'b1) begin bad++; $display("FAIL rstmid_setup: got wvalid=%b rvalid=%b want 0010/1", bus.ch_wvalid_o, bus.S00_AXI_rvalid); end
    #2 rst = 1'b1;
    #1;
    total++; if ({bus.S00_AXI_awready, bus.S00_AXI_wready, bus.S00_AXI_arready, bus.S00_AXI_bvalid, bus.S00_AXI_rvalid, bus.ch_wvalid_o, bus.ch_rready_o} !== '0) begin bad++; $display("FAIL rstmid_flags: got nonzero handshake outputs want 0"); end
    total++; if ({bus.ch_wdata_o, bus.S00_AXI_rdata, bus.S00_AXI_bresp, bus.S00_AXI_rresp} !== '0) begin bad++; $display("FAIL rstmid_data: got nonzero data outputs want 0"); end
    step();
    #3 rst = 1'b0;
    step(); step();
    total++; if ({bus.S00_AXI_awready, bus.S00_AXI_wready, bus.S00_AXI_arready} !== 3'b111) begin bad++; $display("FAIL rstmid_ready: got %b want 111", {bus.S00_AXI_awready, bus.S00_AXI_wready, bus.S00_AXI_arready}); end
    axi_read(6'h09, 32'h0F0F1234, 0, 1'b0, 0, resp, rd, seen, cyc, bh, mu, ra, hg);
    total++; if (hg || resp !== 2'b00 || rd !== 32'h0F0F1234 || seen !== 4'b0100) begin bad++; $display("FAIL rstmid_read: got %b/%h/%b want 00/0f0f1234/0100", resp, rd, seen); end
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d, rd; logic [1:0] resp; logic [N_CH-1:0] seen;
    int dly, stall, cyc; logic err, fin; bit bd, bh, mu, hg;
    for (int i = 0; i < 24; i++) begin
      a = ADDR_W'($urandom_range(0, 63)); d = $urandom; dly = $urandom_range(0, 10);
      err = 1'($urandom_range(0, 1)); stall = $urandom_range(0, 3);
      if (i % 2 == 0) begin
        axi_write(a, d, $urandom_range(0, 2), dly, err, stall, resp, seen, cyc, bd, bh, mu, fin, hg);
        rd = '0;
      end else begin
        axi_read(a, d, dly, err, stall, resp, rd, seen, cyc, bh, mu, fin, hg);
        bd = (rd !== ((exp_resp(a, dly, err) == 2'b11 || dly >= int'(TO)) ? '0 : d));
      end
      total++; if (hg || resp !== exp_resp(a, dly, err)) begin bad++; $display("FAIL rand%0d_resp: addr=%h got %b want %b", i, a, resp, exp_resp(a, dly, err)); end
      total++; if (seen !== exp_onehot(a) || cyc != exp_cycles(a, dly)) begin bad++; $display("FAIL rand%0d_chan: addr=%h got %b/%0d want %b/%0d", i, a, seen, cyc, exp_onehot(a), exp_cycles(a, dly)); end
      total++; if (bd || bh || mu || fin !== 1'b0) begin bad++; $display("FAIL rand%0d_data: got data=%0d hold=%0d multi=%0d after=%b want 0", i, bd, bh, mu, fin); end
    end
  endtask

  initial begin
    bus.S00_AXI_awaddr = '0; bus.S00_AXI_awvalid = 1'b0; bus.S00_AXI_wdata = '0; bus.S00_AXI_wvalid = 1'b0;
    bus.S00_AXI_bready = 1'b0; bus.S00_AXI_araddr = '0; bus.S00_AXI_arvalid = 1'b0; bus.S00_AXI_rready = 1'b0;
    bus.ch_wready_i = '0; bus.ch_werror_i = '0; bus.ch_rvalid_i = '0; bus.ch_rdata_i = '0; bus.ch_rerror_i = '0;
    #1;
    test_reset();
    test_write_w_first();
    test_read_error();
    test_decerr();
    test_timeout();
    test_concurrent();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish before 500000");
    $fatal(1, "watchdog expired");
  end
endmodule
